// File: rtl/act_quant_lanes_pkg.sv
// act_pkg: shared definitions for the activation/requantisation stage.
// Holds the activation mode encoding, default geometry constants and the
// lane slice helper used to locate a lane inside a packed beat.
package act_pkg;

  typedef enum logic [1:0] {
    MODE_LIN   = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_CLIP  = 2'd2,
    MODE_LEAKY = 2'd3
  } mode_e;

  localparam int DEF_WIDTH_IN  = 16;
  localparam int DEF_WIDTH_OUT = 8;
  localparam int DEF_LANES     = 4;
  localparam int DEF_SHIFT_W   = 4;
  localparam int DEF_CNT_W     = 16;

  // Lowest bit of lane 'lane' in a beat packed at 'width' bits per lane.
  function automatic int laneLsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/act_quant_lanes_lane.sv
// act_lane: per-lane combinational datapath, split at the S1/S2 boundary.
// Ports:
//   i_x, i_mode, i_clip, i_leak, i_shift -> o_s1Val : activation followed by
//     the rounding arithmetic right shift (WIDTH_IN+1 bits, value for S1)
//   i_s1Val -> o_q, o_sat : saturation of the registered S1 value to a
//     signed WIDTH_OUT result plus a clamp flag (value for S2)
module act_lane
  import act_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int SHIFT_W   = DEF_SHIFT_W
) (
  input  logic signed [WIDTH_IN-1:0]  i_x,
  input  mode_e                       i_mode,
  input  logic        [WIDTH_IN-1:0]  i_clip,
  input  logic        [2:0]           i_leak,
  input  logic        [SHIFT_W-1:0]   i_shift,
  output logic signed [WIDTH_IN:0]    o_s1Val,
  input  logic signed [WIDTH_IN:0]    i_s1Val,
  output logic signed [WIDTH_OUT-1:0] o_q,
  output logic                        o_sat
);

  localparam logic signed [WIDTH_IN:0] SAT_MAX = (WIDTH_IN+1)'((2 ** (WIDTH_OUT - 1)) - 1);
  localparam logic signed [WIDTH_IN:0] SAT_MIN = -SAT_MAX - (WIDTH_IN+1)'(1);

  logic signed [WIDTH_IN-1:0] w_relu;
  logic signed [WIDTH_IN-1:0] w_act;
  logic signed [WIDTH_IN:0]   w_ext;
  logic signed [WIDTH_IN:0]   w_round;

  // Activation. The clip ceiling is unsigned, so the comparison is done on
  // the (non-negative) ReLU value as unsigned; the result never exceeds the
  // ReLU value and therefore always fits the signed input width.
  always_comb begin
    w_relu = i_x[WIDTH_IN-1] ? '0 : i_x;
    w_act  = i_x;
    case (i_mode)
      MODE_LIN:   w_act = i_x;
      MODE_RELU:  w_act = w_relu;
      MODE_CLIP:  w_act = ($unsigned(w_relu) > i_clip) ? $signed(i_clip) : w_relu;
      MODE_LEAKY: w_act = i_x[WIDTH_IN-1] ? (i_x >>> i_leak) : i_x;
      default:    w_act = i_x;
    endcase
  end

  // Round half up: add 2^(shift-1) in a one-bit-wider intermediate so the
  // add cannot overflow, then arithmetic shift (floor).
  always_comb begin
    w_ext   = {w_act[WIDTH_IN-1], w_act};
    w_round = '0;
    if (i_shift != '0) begin
      w_round = (WIDTH_IN+1)'(1) << (i_shift - SHIFT_W'(1));
    end
    o_s1Val = (w_ext + w_round) >>> i_shift;
  end

  // Saturation to the signed output range.
  always_comb begin
    o_q   = i_s1Val[WIDTH_OUT-1:0];
    o_sat = 1'b0;
    if (i_s1Val > SAT_MAX) begin
      o_q   = SAT_MAX[WIDTH_OUT-1:0];
      o_sat = 1'b1;
    end else if (i_s1Val < SAT_MIN) begin
      o_q   = SAT_MIN[WIDTH_OUT-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/act_quant_lanes.sv
// act_quant_lanes: multi-lane activation + requantisation, two-stage pipeline.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data: input beats, LANES signed WIDTH_IN lanes
//   cfg_mode/clip/leak/shift : configuration captured with each accepted beat
//   out_valid/out_ready      : output handshake
//   out_data/out_sat         : saturated WIDTH_OUT lanes and per-lane clamp flags
//   sat_count/cnt_clr        : sticky saturated-lane counter and its clear
module act_quant_lanes
  import act_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int LANES     = DEF_LANES,
  parameter int SHIFT_W   = DEF_SHIFT_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*WIDTH_IN-1:0]    in_data,
  input  logic [1:0]                   cfg_mode,
  input  logic [WIDTH_IN-1:0]          cfg_clip,
  input  logic [2:0]                   cfg_leak,
  input  logic [SHIFT_W-1:0]           cfg_shift,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WIDTH_OUT-1:0]   out_data,
  output logic [LANES-1:0]             out_sat,
  output logic [CNT_W-1:0]             sat_count,
  input  logic                         cnt_clr
);

  localparam int S1W = WIDTH_IN + 1;

  logic                         w_en1;
  logic                         w_en2;
  mode_e                        w_mode;
  logic [LANES*S1W-1:0]         w_s1Next;
  logic [LANES*WIDTH_OUT-1:0]   w_q;
  logic [LANES-1:0]             w_sat;
  logic [CNT_W-1:0]             w_satPop;
  logic [CNT_W:0]               w_cntSum;

  logic                         r_s1Valid;
  logic                         r_s2Valid;
  logic [LANES*S1W-1:0]         r_s1Val;
  logic [LANES*WIDTH_OUT-1:0]   r_outData;
  logic [LANES-1:0]             r_outSat;
  logic [CNT_W-1:0]             r_satCount;

  // A stage may load when it is empty or when the stage after it moves.
  assign w_en2    = !r_s2Valid || out_ready;
  assign w_en1    = !r_s1Valid || w_en2;
  assign in_ready = w_en1;
  assign w_mode   = mode_e'(cfg_mode);

  assign out_valid = r_s2Valid;
  assign out_data  = r_outData;
  assign out_sat   = r_outSat;
  assign sat_count = r_satCount;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .WIDTH_IN (WIDTH_IN),
      .WIDTH_OUT(WIDTH_OUT),
      .SHIFT_W  (SHIFT_W)
    ) u_lane (
      .i_x    (in_data[laneLsb(g, WIDTH_IN) +: WIDTH_IN]),
      .i_mode (w_mode),
      .i_clip (cfg_clip),
      .i_leak (cfg_leak),
      .i_shift(cfg_shift),
      .o_s1Val(w_s1Next[laneLsb(g, S1W) +: S1W]),
      .i_s1Val(r_s1Val[laneLsb(g, S1W) +: S1W]),
      .o_q    (w_q[laneLsb(g, WIDTH_OUT) +: WIDTH_OUT]),
      .o_sat  (w_sat[g])
    );
  end

  // Number of clamped lanes in the beat currently presented downstream.
  always_comb begin
    w_satPop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_satPop = w_satPop + CNT_W'(r_outSat[i]);
    end
    w_cntSum = {1'b0, r_satCount} + {1'b0, w_satPop};
  end

  // Pipeline registers and the sticky saturation counter. Data registers
  // only load alongside a valid beat so a held output stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid  <= 1'b0;
      r_s2Valid  <= 1'b0;
      r_s1Val    <= '0;
      r_outData  <= '0;
      r_outSat   <= '0;
      r_satCount <= '0;
    end else begin
      if (w_en1) begin
        r_s1Valid <= in_valid;
        if (in_valid) begin
          r_s1Val <= w_s1Next;
        end
      end
      if (w_en2) begin
        r_s2Valid <= r_s1Valid;
        if (r_s1Valid) begin
          r_outData <= w_q;
          r_outSat  <= w_sat;
        end
      end
      if (cnt_clr) begin
        r_satCount <= '0;
      end else if (r_s2Valid && out_ready) begin
        r_satCount <= w_cntSum[CNT_W] ? '1 : w_cntSum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_act_quant_lanes.sv
// tb_act_quant_lanes: directed self-checking bench for act_quant_lanes.
module tb_act_quant_lanes;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_clip;
  logic [2:0]  cfg_leak;
  logic [3:0]  cfg_shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_sat;
  logic [15:0] sat_count;
  logic        cnt_clr;

  int checkCount = 0;
  int passCount  = 0;

  act_quant_lanes dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .cfg_mode (cfg_mode),
    .cfg_clip (cfg_clip),
    .cfg_leak (cfg_leak),
    .cfg_shift(cfg_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .sat_count(sat_count),
    .cnt_clr  (cnt_clr)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane 0 sits in the least significant slice.
  function automatic logic [63:0] packIn(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic logic [31:0] packOut(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  // One comparison: counts it, and reports a mismatch with both values.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Sends one beat into an empty pipeline (called at a falling edge) and
  // returns at the falling edge where the result should be valid, checking
  // that it is not valid one cycle early.
  task automatic applyStimulus(input string tag, input logic [1:0] mode, input logic [15:0] clip,
                               input logic [2:0] leak, input logic [3:0] shift, input logic [63:0] data);
    cfg_mode  = mode;
    cfg_clip  = clip;
    cfg_leak  = leak;
    cfg_shift = shift;
    in_data   = data;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    cfg_mode = 2'd0;
    checkOutput({tag, "_early_valid"}, out_valid, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full directed vector: result, clamp flags and counter after the handshake.
  task automatic runVector(input string tag, input logic [1:0] mode, input logic [15:0] clip,
                           input logic [2:0] leak, input logic [3:0] shift, input logic [63:0] data,
                           input logic [31:0] expData, input logic [3:0] expSat, input logic [15:0] expCount);
    applyStimulus(tag, mode, clip, leak, shift, data);
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_data"}, out_data, expData);
    checkOutput({tag, "_sat"}, out_sat, expSat);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_count"}, sat_count, expCount);
    checkOutput({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    int  acc;
    int  got;
    int  cyc;
    logic fireIn;
    logic fireOut;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_mode  = 2'd0;
    cfg_clip  = '0;
    cfg_leak  = '0;
    cfg_shift = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset state
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_sat", out_sat, 0);
    checkOutput("rst_sat_count", sat_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1);

    // Directed activation / requant vectors
    runVector("relu", 2'd1, 16'd0, 3'd0, 4'd0, packIn(300, -5, 127, 0),
              packOut(127, 0, 127, 0), 4'b0001, 16'd1);
    runVector("lin_sh4", 2'd0, 16'd0, 3'd0, 4'd4, packIn(-4096, 4095, 24, -24),
              packOut(-128, 127, 2, -1), 4'b0011, 16'd3);
    runVector("leaky", 2'd3, 16'd0, 3'd2, 4'd0, packIn(-100, -3, 50, -512),
              packOut(-25, -1, 50, -128), 4'b0000, 16'd3);
    runVector("clip96", 2'd2, 16'd96, 3'd0, 4'd0, packIn(200, 96, -1, 50),
              packOut(96, 96, 0, 50), 4'b0000, 16'd3);
    runVector("lin_sh15", 2'd0, 16'd0, 3'd0, 4'd15, packIn(32767, -32768, 16384, -16385),
              packOut(1, -1, 1, -1), 4'b0000, 16'd3);
    runVector("lin_edges", 2'd0, 16'd0, 3'd0, 4'd0, packIn(-128, 127, -129, 128),
              packOut(-128, 127, -128, 127), 4'b1100, 16'd5);
    runVector("lin_sh1", 2'd0, 16'd0, 3'd0, 4'd1, packIn(-3, 3, -1, 1),
              packOut(-1, 2, 0, 1), 4'b0000, 16'd5);
    runVector("clip_max", 2'd2, 16'hFFFF, 3'd0, 4'd8, packIn(32767, -32768, 256, 383),
              packOut(127, 0, 1, 1), 4'b0001, 16'd6);

    // Back-pressure: counting beats, output stalled for the first 5 cycles
    acc = 0;
    got = 0;
    cyc = 0;
    cfg_mode  = 2'd0;
    cfg_shift = 4'd0;
    while ((got < 8) && (cyc < 100)) begin
      out_ready = (cyc >= 5);
      in_valid  = (acc < 8);
      in_data   = packIn(acc * 4, acc * 4 + 1, acc * 4 + 2, acc * 4 + 3);
      #1;
      fireIn  = in_valid && in_ready;
      fireOut = out_valid && out_ready;
      if (cyc == 4) begin
        checkOutput("bp_in_ready_low", in_ready, 0);
        checkOutput("bp_stall_accepts", acc, 2);
        checkOutput("bp_hold_valid", out_valid, 1);
        checkOutput("bp_hold_data", out_data, packOut(0, 1, 2, 3));
      end
      if (fireOut) begin
        checkOutput($sformatf("bp_beat%0d", got), out_data,
                    packOut(got * 4, got * 4 + 1, got * 4 + 2, got * 4 + 3));
        got++;
      end
      @(posedge clk);
      if (fireIn) acc++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("bp_all_beats", got, 8);
    checkOutput("bp_accepted", acc, 8);
    checkOutput("bp_count_unchanged", sat_count, 6);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cfg_mode  = 2'd1;
    in_data   = packIn(1000, 1000, 1000, 1000);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("mid_full_valid", out_valid, 1);
    checkOutput("mid_full_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_count", sat_count, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mid_no_stale", out_valid, 0);
    runVector("after_rst", 2'd1, 16'd0, 3'd0, 4'd0, packIn(300, -5, 127, 0),
              packOut(127, 0, 127, 0), 4'b0001, 16'd1);

    // Counter saturation: stream fully-saturating beats past the limit
    cfg_mode  = 2'd1;
    cfg_shift = 4'd0;
    in_data   = packIn(1000, 1000, 1000, 1000);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (16400) @(negedge clk);
    checkOutput("cnt_sticky", sat_count, 16'hFFFF);
    checkOutput("cnt_beat_sat", out_sat, 4'hF);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    checkOutput("cnt_clr_priority", sat_count, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
